// File: rtl/turn_signal_input.sv
// turn_signal_input
//   Upstream conditioner for the tail-light sequencer. Three raw buttons
//   (left, right, hazard) are synchronised, debounced and priority-encoded
//   into a registered 2-bit direction code:
//     00 none, 10 left, 01 right, 11 hazard.
//   A short press is latched until the sequencer's next slow tick consumes
//   it, so a press that starts and ends between two ticks is not lost.
//
//   Optional feature macro: HAZARD_TOGGLE_EN
//     Defined   - each hazard press toggles a sticky hazard mode. While the
//                 mode is on, direction is forced to 11. The hazard level no
//                 longer feeds the requested code.
//     Undefined - hazard is momentary, like left/right.
//
//   DEBOUNCE_CYCLES must be representable in CNT_W bits (2**CNT_W > DEBOUNCE_CYCLES).
module turn_signal_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_hazard,
  input  logic       tick,
  output logic [1:0] direction,
  output logic       pending
);

  localparam int N_BTN     = 3;
  localparam int IDX_LEFT  = 0;
  localparam int IDX_RIGHT = 1;
  localparam int IDX_HAZ   = 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    DIR_NONE   = 2'b00,
    DIR_RIGHT  = 2'b01,
    DIR_LEFT   = 2'b10,
    DIR_HAZARD = 2'b11
  } dir_e;

  // Raw buttons packed by index so every per-button stage is a loop.
  logic [N_BTN-1:0] w_raw;
  assign w_raw = {btn_hazard, btn_right, btn_left};

  // ---------------------------------------------------------------------
  // Two-flop synchroniser per button
  // ---------------------------------------------------------------------
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  // Bring the asynchronous buttons into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: one counter per button
  // ---------------------------------------------------------------------
  logic [N_BTN-1:0] r_deb;
  logic [N_BTN-1:0] w_deb_nxt;
  logic [CNT_W-1:0] r_cnt     [N_BTN];
  logic [CNT_W-1:0] w_cnt_nxt [N_BTN];

  // Count cycles of disagreement; flip the level once it has lasted long enough.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      // NOTE: defaults first so no path through the block leaves a signal
      // unassigned, which would infer a latch.
      w_deb_nxt[i] = r_deb[i];
      w_cnt_nxt[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_deb_nxt[i] = r_sync2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced levels and their counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_deb <= '0;
      // NOTE: the counter array is control state, not storage, so it is
      // reset element by element; a reset mid-debounce must abort it.
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_deb <= w_deb_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Press event: the cycle in which a debounced level rises.
  logic [N_BTN-1:0] w_press;
  assign w_press = w_deb_nxt & ~r_deb;

  // ---------------------------------------------------------------------
  // Sticky hazard mode (optional)
  // ---------------------------------------------------------------------
`ifdef HAZARD_TOGGLE_EN
  logic r_haz_mode;

  // Each hazard press flips the sticky hazard mode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_haz_mode <= 1'b0;
    end else if (w_press[IDX_HAZ]) begin
      r_haz_mode <= ~r_haz_mode;
    end
  end

  // Hazard presses are consumed by the mode flop, not by the latch.
  logic w_haz_ev;
  assign w_haz_ev = 1'b0;
  logic w_haz_lvl;
  assign w_haz_lvl = 1'b0;
`else
  logic w_haz_ev;
  assign w_haz_ev = w_press[IDX_HAZ];
  logic w_haz_lvl;
  assign w_haz_lvl = r_deb[IDX_HAZ];
`endif

  // ---------------------------------------------------------------------
  // Requested code from the live debounced levels
  // ---------------------------------------------------------------------
  dir_e w_req;

  // Hazard, or left and right together, outranks a single side.
  always_comb begin
    w_req = DIR_NONE;
    if (w_haz_lvl || (r_deb[IDX_LEFT] && r_deb[IDX_RIGHT])) begin
      w_req = DIR_HAZARD;
    end else if (r_deb[IDX_LEFT]) begin
      w_req = DIR_LEFT;
    end else if (r_deb[IDX_RIGHT]) begin
      w_req = DIR_RIGHT;
    end
  end

  // ---------------------------------------------------------------------
  // Press latch
  // ---------------------------------------------------------------------
  logic w_ev_valid;
  dir_e w_ev_code;

  // Encode this cycle's press events with the same priority as the request.
  always_comb begin
    w_ev_valid = 1'b1;
    w_ev_code  = DIR_NONE;
    if (w_haz_ev || (w_press[IDX_LEFT] && w_press[IDX_RIGHT])) begin
      w_ev_code = DIR_HAZARD;
    end else if (w_press[IDX_LEFT]) begin
      w_ev_code = DIR_LEFT;
    end else if (w_press[IDX_RIGHT]) begin
      w_ev_code = DIR_RIGHT;
    end else begin
      w_ev_valid = 1'b0;
    end
  end

  dir_e r_lat;

  // A new press loads the latch even on a tick cycle; otherwise a tick consumes it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lat <= DIR_NONE;
    end else if (w_ev_valid) begin
      r_lat <= w_ev_code;
    end else if (tick) begin
      r_lat <= DIR_NONE;
    end
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  dir_e w_dir_nxt;

  // Live request wins; otherwise show the unconsumed latched press.
  always_comb begin
    w_dir_nxt = (w_req != DIR_NONE) ? w_req : r_lat;
`ifdef HAZARD_TOGGLE_EN
    if (r_haz_mode) begin
      w_dir_nxt = DIR_HAZARD;
    end
`endif
  end

  dir_e r_direction;
  logic r_pending;

  // Register direction and the pending flag for the sequencer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_direction <= DIR_NONE;
      r_pending   <= 1'b0;
    end else begin
      r_direction <= w_dir_nxt;
      r_pending   <= (r_lat != DIR_NONE);
    end
  end

  assign direction = r_direction;
  assign pending   = r_pending;

endmodule

// File: tb/tb_turn_signal_input.sv
// tb_turn_signal_input
//   Directed bench for turn_signal_input with DEBOUNCE_CYCLES=4, CNT_W=3.
//   Timing reference inside each step: inputs change 1 ns after an edge,
//   so a level driven after edge 0 reaches direction at edge 7
//   (2 sync + 4 debounce + 1 output register).
module tb_turn_signal_input;

  logic       clock;
  logic       reset;
  logic       btn_left;
  logic       btn_right;
  logic       btn_hazard;
  logic       tick;
  logic [1:0] direction;
  logic       pending;

  int checks = 0;
  int errors = 0;

  turn_signal_input #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_hazard(btn_hazard),
    .tick      (tick),
    .direction (direction),
    .pending   (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_hazard = 1'b0;
    tick       = 1'b0;

    // ---- reset state ----
    cyc(2);
    check("rst_dir", direction, 2'b00);
    check("rst_pend", {1'b0, pending}, 2'b00);
    reset = 1'b0;
    cyc(1);
    check("rel_dir", direction, 2'b00);
    check("rel_pend", {1'b0, pending}, 2'b00);
    cyc(2);

    // ---- glitch rejection: left high for 3 cycles ----
    btn_left = 1'b1;
    cyc(3);
    btn_left = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("glitch_dir", direction, 2'b00);
      check("glitch_pend", {1'b0, pending}, 2'b00);
    end

    // ---- short press latch: right held 8 cycles, tick 12 cycles later ----
    btn_right = 1'b1;
    cyc(6);                                          // e6
    check("short_dir_e6", direction, 2'b00);
    check("short_pend_e6", {1'b0, pending}, 2'b00);
    cyc(1);                                          // e7
    check("short_dir_e7", direction, 2'b01);
    check("short_pend_e7", {1'b0, pending}, 2'b01);
    cyc(1);                                          // e8
    btn_right = 1'b0;
    cyc(12);                                         // e20, level fell at e14
    check("short_dir_held", direction, 2'b01);
    check("short_pend_held", {1'b0, pending}, 2'b01);
    tick = 1'b1;
    cyc(1);                                          // e21, latch cleared here
    tick = 1'b0;
    check("short_dir_tick", direction, 2'b01);
    check("short_pend_tick", {1'b0, pending}, 2'b01);
    cyc(1);                                          // e22
    check("short_dir_clr", direction, 2'b00);
    check("short_pend_clr", {1'b0, pending}, 2'b00);
    cyc(2);

    // ---- priority: left+right together, then right released ----
    btn_left  = 1'b1;
    btn_right = 1'b1;
    cyc(7);                                          // e7
    check("prio_both", direction, 2'b11);
    check("prio_both_pend", {1'b0, pending}, 2'b01);
    cyc(3);                                          // e10
    btn_right = 1'b0;
    cyc(6);                                          // e16
    check("prio_r_rel_e16", direction, 2'b11);
    cyc(1);                                          // e17
    check("prio_left_only", direction, 2'b10);
    tick = 1'b1;
    cyc(1);                                          // e18, latch 11 consumed
    tick = 1'b0;
    btn_left = 1'b0;
    cyc(1);                                          // e19
    check("prio_pend_clr", {1'b0, pending}, 2'b00);
    check("prio_live_left", direction, 2'b10);
    cyc(5);                                          // e24
    check("prio_l_rel_e24", direction, 2'b10);
    cyc(1);                                          // e25
    check("prio_none", direction, 2'b00);
    cyc(2);

    // ---- press event coincident with tick ----
    btn_left = 1'b1;
    cyc(5);                                          // e5
    tick = 1'b1;
    cyc(1);                                          // e6: press and tick together
    tick = 1'b0;
    btn_left = 1'b0;
    cyc(1);                                          // e7
    check("coll_pend_e7", {1'b0, pending}, 2'b01);
    check("coll_dir_e7", direction, 2'b10);
    cyc(6);                                          // e13, level fell at e12
    check("coll_dir_lat", direction, 2'b10);
    check("coll_pend_lat", {1'b0, pending}, 2'b01);
    cyc(1);                                          // e14
    tick = 1'b1;
    cyc(1);                                          // e15
    tick = 1'b0;
    check("coll_dir_e15", direction, 2'b10);
    check("coll_pend_e15", {1'b0, pending}, 2'b01);
    cyc(1);                                          // e16
    check("coll_dir_clr", direction, 2'b00);
    check("coll_pend_clr", {1'b0, pending}, 2'b00);
    cyc(2);

    // ---- reset mid-pending drops the latched press ----
    btn_left = 1'b1;
    cyc(4);                                          // e4
    btn_left = 1'b0;
    cyc(7);                                          // e11, level fell at e10
    check("rstp_dir_pre", direction, 2'b10);
    check("rstp_pend_pre", {1'b0, pending}, 2'b01);
    reset = 1'b1;
    #1;
    check("rstp_dir_async", direction, 2'b00);
    check("rstp_pend_async", {1'b0, pending}, 2'b00);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("rstp_dir_rel", direction, 2'b00);
    check("rstp_pend_rel", {1'b0, pending}, 2'b00);
    cyc(10);
    check("rstp_dir_late", direction, 2'b00);
    check("rstp_pend_late", {1'b0, pending}, 2'b00);
    cyc(2);

`ifdef HAZARD_TOGGLE_EN
    // ---- hazard toggle: two separate presses ----
    btn_hazard = 1'b1;
    cyc(7);                                          // e7
    check("tog_on", direction, 2'b11);
    cyc(1);                                          // e8
    btn_hazard = 1'b0;
    cyc(12);                                         // e20
    check("tog_sticky", direction, 2'b11);
    check("tog_pend", {1'b0, pending}, 2'b00);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(9);                                          // e30
    check("tog_after_tick", direction, 2'b11);
    btn_hazard = 1'b1;
    cyc(6);                                          // e36, mode toggles off here
    check("tog_e36", direction, 2'b11);
    cyc(1);                                          // e37
    check("tog_off", direction, 2'b00);
    cyc(1);
    btn_hazard = 1'b0;
    cyc(12);
    check("tog_off_late", direction, 2'b00);
`else
    // ---- momentary hazard ----
    btn_hazard = 1'b1;
    cyc(6);                                          // e6
    check("haz_e6", direction, 2'b00);
    cyc(1);                                          // e7
    check("haz_on", direction, 2'b11);
    cyc(1);                                          // e8
    btn_hazard = 1'b0;
    cyc(7);                                          // e15, level fell at e14
    check("haz_lat", direction, 2'b11);
    check("haz_pend", {1'b0, pending}, 2'b01);
    tick = 1'b1;
    cyc(1);                                          // e16
    tick = 1'b0;
    cyc(1);                                          // e17
    check("haz_clr", direction, 2'b00);
    check("haz_pend_clr", {1'b0, pending}, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
